// File: rtl/gfx_line_arb.sv
// Round-robin scheduler sharing one Bresenham line engine among NUM_REQ clients.
// Accept-to-first-pixel 4 cycles; pix_ready=0 freezes the engine, the held pixel and the line in flight.

module gfx_line #(
    parameter int XB = 10,
    parameter int YB = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          enable_i,
    input  logic [XB-1:0] x0_i,
    input  logic [YB-1:0] y0_i,
    input  logic [XB-1:0] x1_i,
    input  logic [YB-1:0] y1_i,
    output logic [XB-1:0] x_o,
    output logic [YB-1:0] y_o,
    output logic          done_o
);
    localparam int EB = ((XB > YB) ? XB : YB) + 3;
    localparam logic signed [EB-1:0] ZERO = '0;

    typedef enum logic [2:0] {E_IDLE, E_INIT0, E_INIT1, E_DRAW, E_DONE} eng_state_e;

    eng_state_e            state_q, state_d;
    logic [XB-1:0]         xa_q, xa_d, xb_q, xb_d, x_q, x_d;
    logic [YB-1:0]         ya_q, ya_d, yb_q, yb_d, y_q, y_d;
    logic                  right_q, right_d;
    logic signed [EB-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d, e2;
    logic                  xstep, ystep;

    always_comb begin
        state_d = state_q;
        xa_d    = xa_q;
        ya_d    = ya_q;
        xb_d    = xb_q;
        yb_d    = yb_q;
        x_d     = x_q;
        y_d     = y_q;
        right_d = right_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        e2      = err_q <<< 1;
        xstep   = (e2 >= dy_q);
        ystep   = (e2 <= dx_q);
        unique case (state_q)
            E_IDLE: begin
                if (start_i) begin
                    // Normalise so the line always runs top to bottom.
                    if (y0_i > y1_i) begin
                        xa_d = x1_i; ya_d = y1_i; xb_d = x0_i; yb_d = y0_i;
                    end else begin
                        xa_d = x0_i; ya_d = y0_i; xb_d = x1_i; yb_d = y1_i;
                    end
                    state_d = E_INIT0;
                end
            end
            E_INIT0: begin
                right_d = (xb_q >= xa_q);
                dx_d    = (xb_q >= xa_q) ? $signed({{(EB-XB){1'b0}}, xb_q - xa_q})
                                         : $signed({{(EB-XB){1'b0}}, xa_q - xb_q});
                dy_d    = -$signed({{(EB-YB){1'b0}}, yb_q - ya_q});
                state_d = E_INIT1;
            end
            E_INIT1: begin
                err_d   = dx_q + dy_q;
                x_d     = xa_q;
                y_d     = ya_q;
                state_d = E_DRAW;
            end
            E_DRAW: begin
                if (enable_i) begin
                    if (x_q == xb_q && y_q == yb_q) begin
                        state_d = E_DONE;
                    end else begin
                        if (xstep) x_d = right_q ? x_q + 1'b1 : x_q - 1'b1;
                        if (ystep) y_d = y_q + 1'b1;
                        err_d = err_q + (xstep ? dy_q : ZERO) + (ystep ? dx_q : ZERO);
                    end
                end
            end
            E_DONE:  state_d = E_IDLE;
            default: state_d = E_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= E_IDLE;
            xa_q    <= '0;
            ya_q    <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            right_q <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            xa_q    <= xa_d;
            ya_q    <= ya_d;
            xb_q    <= xb_d;
            yb_q    <= yb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            right_q <= right_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign done_o = (state_q == E_DONE);
endmodule

module gfx_line_arb #(
    parameter  int FB_WIDTH  = 640,
    parameter  int FB_HEIGHT = 480,
    parameter  int NUM_REQ   = 2,
    localparam int XB        = $clog2(FB_WIDTH),
    localparam int YB        = $clog2(FB_HEIGHT),
    localparam int OB        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*XB-1:0] req_x0_i,
    input  logic [NUM_REQ*YB-1:0] req_y0_i,
    input  logic [NUM_REQ*XB-1:0] req_x1_i,
    input  logic [NUM_REQ*YB-1:0] req_y1_i,
    output logic [NUM_REQ-1:0]    req_done_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [XB-1:0]         pix_x_o,
    output logic [YB-1:0]         pix_y_o,
    output logic [OB-1:0]         pix_owner_o,
    output logic                  busy_o
);
    typedef enum logic [2:0] {S_ARB, S_START, S_WAIT0, S_WAIT1, S_DRAW} state_e;

    state_e        state_q, state_d;
    logic [OB-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [XB-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [YB-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [OB-1:0] grant, cand;
    logic          found;
    int            idx, nxt;
    logic          eng_start, eng_enable, eng_done;
    logic [XB-1:0] eng_x;
    logic [YB-1:0] eng_y;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = OB'(idx);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        nxt = int'(grant) + 1;
        if (nxt >= NUM_REQ) nxt = 0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        req_ready_o = '0;
        req_done_o  = '0;
        eng_start   = 1'b0;
        eng_enable  = 1'b0;
        pix_valid_o = 1'b0;
        unique case (state_q)
            S_ARB: begin
                if (found) begin
                    req_ready_o[grant] = 1'b1;
                    x0_d     = req_x0_i[grant*XB +: XB];
                    y0_d     = req_y0_i[grant*YB +: YB];
                    x1_d     = req_x1_i[grant*XB +: XB];
                    y1_d     = req_y1_i[grant*YB +: YB];
                    owner_d  = grant;
                    rr_ptr_d = OB'(nxt);
                    state_d  = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                state_d   = S_WAIT0;
            end
            S_WAIT0: state_d = S_WAIT1;
            S_WAIT1: state_d = S_DRAW;
            S_DRAW: begin
                eng_enable  = pix_ready_i;
                pix_valid_o = !eng_done;
                if (eng_done) begin
                    req_done_o[owner_q] = 1'b1;
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
        pix_x_o = pix_valid_o ? eng_x : '0;
        pix_y_o = pix_valid_o ? eng_y : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
        end
    end

    gfx_line #(.XB(XB), .YB(YB)) u_line (
        .clk      (clk),
        .reset    (reset),
        .start_i  (eng_start),
        .enable_i (eng_enable),
        .x0_i     (x0_q),
        .y0_i     (y0_q),
        .x1_i     (x1_q),
        .y1_i     (y1_q),
        .x_o      (eng_x),
        .y_o      (eng_y),
        .done_o   (eng_done)
    );

    assign pix_owner_o = owner_q;
    assign busy_o      = (state_q != S_ARB);
endmodule
